// File: rtl/secure_mem_ctrl.sv
// secure_mem_ctrl
//   Key-authenticated, XOR-encrypted data memory behind a valid/ready
//   request channel. Each entry holds plaintext ^ key_reg. Every command
//   is checked against key_reg. MAX_FAIL consecutive authentication
//   failures lock the controller out for LOCK_CYCLES cycles. An
//   authenticated rekey walks the whole array and re-encrypts it under
//   the new key.
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   asynchronous, active-high reset
//   req_valid  in   request present
//   req_ready  out  request accepted when req_valid && req_ready (IDLE only)
//   req_op     in   00 read, 01 write, 10 rekey, 11 reserved
//   req_addr   in   entry address (ignored for rekey)
//   req_wdata  in   write data, or the new key for rekey
//   req_key    in   presented key
//   rsp_valid  out  response present, held until rsp_ready
//   rsp_ready  in   response consumed
//   rsp_rdata  out  decrypted read data; 0 on error and for non-read ops
//   rsp_err    out  authentication failure or reserved op
//   locked     out  controller in lockout
//   fail_count out  consecutive authentication failures
module secure_mem_ctrl #(
  parameter int                DATA_W      = 32,
  parameter int                ADDR_W      = 5,
  parameter logic [DATA_W-1:0] RESET_KEY   = 32'hA5A5_5A5A,
  parameter int                MAX_FAIL    = 3,
  parameter int                LOCK_CYCLES = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic [1:0]                    req_op,
  input  logic [ADDR_W-1:0]             req_addr,
  input  logic [DATA_W-1:0]             req_wdata,
  input  logic [DATA_W-1:0]             req_key,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [DATA_W-1:0]             rsp_rdata,
  output logic                          rsp_err,
  output logic                          locked,
  output logic [$clog2(MAX_FAIL+1)-1:0] fail_count
);

  localparam int DEPTH  = 2 ** ADDR_W;
  localparam int FAIL_W = $clog2(MAX_FAIL + 1);
  localparam int LOCK_W = $clog2(LOCK_CYCLES + 1);

  localparam logic [1:0] OP_RD    = 2'b00;
  localparam logic [1:0] OP_WR    = 2'b01;
  localparam logic [1:0] OP_REKEY = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCESS,
    S_RESP,
    S_REKEY,
    S_LOCKED
  } state_t;

  state_t              state_q;
  logic [1:0]          op_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   key_q;
  logic [DATA_W-1:0]   key_reg_q;
  logic [FAIL_W-1:0]   fail_q;
  logic [LOCK_W-1:0]   lock_cnt_q;
  logic [ADDR_W-1:0]   idx_q;
  logic                rsp_valid_q;
  logic [DATA_W-1:0]   rsp_rdata_q;
  logic                rsp_err_q;
  logic                locked_q;

  // Storage is not reset: a reset in the middle of a rekey leaves the
  // array partially re-encrypted and software must rewrite it.
  logic [DATA_W-1:0]   mem [DEPTH];

  logic                auth;
  logic [ADDR_W-1:0]   mem_ra;
  logic [DATA_W-1:0]   mem_rd;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_wa;
  logic [DATA_W-1:0]   mem_wd;

  assign auth   = (key_q == key_reg_q);
  // During rekey the walk index selects the entry; otherwise the latched address.
  assign mem_ra = (state_q == S_REKEY) ? idx_q : addr_q;
  assign mem_rd = mem[mem_ra];

  // Single write port: authenticated write in ACCESS, or the rekey
  // read-modify-write that swaps the old key for the new one in place.
  always_comb begin
    mem_we = 1'b0;
    mem_wa = addr_q;
    mem_wd = wdata_q ^ key_reg_q;
    if (state_q == S_ACCESS && op_q == OP_WR && auth) begin
      mem_we = 1'b1;
    end else if (state_q == S_REKEY) begin
      mem_we = 1'b1;
      mem_wa = idx_q;
      mem_wd = mem_rd ^ key_reg_q ^ wdata_q;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_wa] <= mem_wd;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      op_q        <= OP_RD;
      addr_q      <= '0;
      wdata_q     <= '0;
      key_q       <= '0;
      key_reg_q   <= RESET_KEY;
      fail_q      <= '0;
      lock_cnt_q  <= '0;
      idx_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      locked_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            op_q    <= req_op;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            key_q   <= req_key;
            state_q <= S_ACCESS;
          end
        end

        S_ACCESS: begin
          rsp_rdata_q <= '0;
          if (op_q == 2'b11) begin
            // Reserved op is an error but not an authentication failure.
            rsp_err_q   <= 1'b1;
            rsp_valid_q <= 1'b1;
            state_q     <= S_RESP;
          end else if (!auth) begin
            rsp_err_q   <= 1'b1;
            fail_q      <= fail_q + FAIL_W'(1);
            rsp_valid_q <= 1'b1;
            state_q     <= S_RESP;
          end else begin
            fail_q    <= '0;
            rsp_err_q <= 1'b0;
            case (op_q)
              OP_RD: begin
                rsp_rdata_q <= mem_rd ^ key_reg_q;
                rsp_valid_q <= 1'b1;
                state_q     <= S_RESP;
              end
              OP_REKEY: begin
                idx_q   <= '0;
                state_q <= S_REKEY;
              end
              default: begin
                rsp_valid_q <= 1'b1;
                state_q     <= S_RESP;
              end
            endcase
          end
        end

        S_REKEY: begin
          idx_q <= idx_q + ADDR_W'(1);
          if (idx_q == {ADDR_W{1'b1}}) begin
            key_reg_q   <= wdata_q;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_valid_q <= 1'b1;
            state_q     <= S_RESP;
          end
        end

        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            if (fail_q == FAIL_W'(MAX_FAIL)) begin
              locked_q   <= 1'b1;
              lock_cnt_q <= LOCK_W'(LOCK_CYCLES);
              state_q    <= S_LOCKED;
            end else begin
              state_q <= S_IDLE;
            end
          end
        end

        S_LOCKED: begin
          // Leaving on the cycle the counter reaches zero keeps locked
          // high for exactly LOCK_CYCLES cycles.
          if (lock_cnt_q <= LOCK_W'(1)) begin
            lock_cnt_q <= '0;
            fail_q     <= '0;
            locked_q   <= 1'b0;
            state_q    <= S_IDLE;
          end else begin
            lock_cnt_q <= lock_cnt_q - LOCK_W'(1);
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_ready  = (state_q == S_IDLE);
  assign rsp_valid  = rsp_valid_q;
  assign rsp_rdata  = rsp_rdata_q;
  assign rsp_err    = rsp_err_q;
  assign locked     = locked_q;
  assign fail_count = fail_q;

endmodule

// File: tb/tb_secure_mem_ctrl.sv
// Directed testbench for secure_mem_ctrl: write/read, bad key, lockout,
// rekey, backpressure, reserved op and asynchronous reset mid-rekey.
module tb_secure_mem_ctrl;

  localparam logic [31:0] RKEY = 32'hA5A5_5A5A;
  localparam logic [31:0] NKEY = 32'h1234_5678;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [4:0]  req_addr;
  logic [31:0] req_wdata;
  logic [31:0] req_key;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        locked;
  logic [1:0]  fail_count;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  secure_mem_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_key    (req_key),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .locked     (locked),
    .fail_count (fail_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      $error("check %s did not match", tag);
    end
  endtask

  // One command: drive at a falling edge, accepted on the next rising edge,
  // count falling edges until rsp_valid, hold rsp_ready low for 'hold'
  // cycles while watching stability, then complete the handshake.
  task automatic txn(input logic [1:0] op, input logic [4:0] addr,
                     input logic [31:0] wd, input logic [31:0] key,
                     input int hold, output int lat, output logic [31:0] rd,
                     output logic er, output logic [1:0] fc, output int unstable);
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = addr;
    req_wdata = wd;
    req_key   = key;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!rsp_valid && lat < 100);
    rd = rsp_rdata;
    er = rsp_err;
    fc = fail_count;
    unstable = 0;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b1 || rsp_rdata !== rd || rsp_err !== er || req_ready !== 1'b0)
        unstable++;
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    $display("txn op=%0d addr=%0d wdata=%08h key=%08h -> lat=%0d rdata=%08h err=%0b fail=%0d",
             op, addr, wd, key, lat, rd, er, fc);
  endtask

  initial begin
    #20000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    int          lat;
    int          unst;
    int          n;
    int          rdy_hi;
    logic [31:0] rd;
    logic        er;
    logic [1:0]  fc;

    reset     = 1'b1;
    req_valid = 1'b0;
    req_op    = 2'b00;
    req_addr  = '0;
    req_wdata = '0;
    req_key   = '0;
    rsp_ready = 1'b0;

    // Reset state
    #12;
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_locked", 32'(locked), 32'd0);
    chk("rst_fail", 32'(fail_count), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1 chk("rst_req_ready", 32'(req_ready), 32'd1);

    // Write then read back
    txn(2'b01, 5'd3, 32'hDEAD_BEEF, RKEY, 0, lat, rd, er, fc, unst);
    chk("wr_lat", lat, 2);
    chk("wr_err", 32'(er), 32'd0);
    chk("wr_rdata", rd, 32'd0);
    txn(2'b00, 5'd3, 32'h0, RKEY, 0, lat, rd, er, fc, unst);
    chk("rd_lat", lat, 2);
    chk("rd_data", rd, 32'hDEAD_BEEF);
    chk("rd_err", 32'(er), 32'd0);

    // Bad key, then a good read clears the failure count
    txn(2'b00, 5'd3, 32'h0, 32'h0, 0, lat, rd, er, fc, unst);
    chk("bad_err", 32'(er), 32'd1);
    chk("bad_rdata", rd, 32'd0);
    chk("bad_fail", 32'(fc), 32'd1);
    txn(2'b00, 5'd3, 32'h0, RKEY, 0, lat, rd, er, fc, unst);
    chk("good_fail_clr", 32'(fc), 32'd0);
    chk("good_data", rd, 32'hDEAD_BEEF);

    // Lockout after three bad-key writes
    txn(2'b01, 5'd3, 32'h1111_1111, 32'h0, 0, lat, rd, er, fc, unst);
    chk("lk1_fail", 32'(fc), 32'd1);
    txn(2'b01, 5'd3, 32'h1111_1111, 32'h0, 0, lat, rd, er, fc, unst);
    chk("lk2_fail", 32'(fc), 32'd2);
    txn(2'b01, 5'd3, 32'h1111_1111, 32'h0, 0, lat, rd, er, fc, unst);
    chk("lk3_fail", 32'(fc), 32'd3);
    chk("lk3_err", 32'(er), 32'd1);
    n = 0;
    rdy_hi = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (locked !== 1'b1) break;
      n++;
      if (req_ready !== 1'b0) rdy_hi++;
    end
    $display("lockout cycles=%0d ready_high=%0d", n, rdy_hi);
    chk("lock_cycles", n, 16);
    chk("lock_ready_low", rdy_hi, 0);
    chk("unlock_ready", 32'(req_ready), 32'd1);
    chk("unlock_fail", 32'(fail_count), 32'd0);
    txn(2'b00, 5'd3, 32'h0, RKEY, 0, lat, rd, er, fc, unst);
    chk("lock_entry_kept", rd, 32'hDEAD_BEEF);

    // Fill and rekey
    n = 0;
    for (int a = 0; a < 32; a++) begin
      txn(2'b01, 5'(a), 32'(a) * 32'h0101_0101, RKEY, 0, lat, rd, er, fc, unst);
      if (er !== 1'b0) n++;
    end
    chk("fill_errs", n, 0);
    txn(2'b10, 5'd0, NKEY, RKEY, 0, lat, rd, er, fc, unst);
    chk("rekey_lat", lat, 34);
    chk("rekey_err", 32'(er), 32'd0);
    txn(2'b00, 5'd31, 32'h0, NKEY, 0, lat, rd, er, fc, unst);
    chk("rekey_rd31", rd, 32'h1F1F_1F1F);
    txn(2'b00, 5'd5, 32'h0, NKEY, 0, lat, rd, er, fc, unst);
    chk("rekey_rd5", rd, 32'h0505_0505);
    txn(2'b00, 5'd31, 32'h0, RKEY, 0, lat, rd, er, fc, unst);
    chk("oldkey_err", 32'(er), 32'd1);
    chk("oldkey_rdata", rd, 32'd0);

    // Backpressure: response held 10 cycles
    txn(2'b00, 5'd7, 32'h0, NKEY, 10, lat, rd, er, fc, unst);
    chk("bp_data", rd, 32'h0707_0707);
    chk("bp_stable", unst, 0);
    chk("bp_fail_clr", 32'(fc), 32'd0);

    // Reserved op leaves fail_count unchanged
    txn(2'b00, 5'd7, 32'h0, 32'h0, 0, lat, rd, er, fc, unst);
    chk("pre11_fail", 32'(fc), 32'd1);
    txn(2'b11, 5'd7, 32'h0, NKEY, 0, lat, rd, er, fc, unst);
    chk("op11_err", 32'(er), 32'd1);
    chk("op11_fail", 32'(fc), 32'd1);
    chk("op11_rdata", rd, 32'd0);
    chk("op11_lat", lat, 2);
    txn(2'b00, 5'd7, 32'h0, NKEY, 0, lat, rd, er, fc, unst);
    chk("post11_fail", 32'(fc), 32'd0);

    // Asynchronous reset while the rekey walk is at index 10
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = 2'b10;
    req_addr  = '0;
    req_wdata = 32'hCAFE_F00D;
    req_key   = NKEY;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (12) @(negedge clk);
    chk("rk_busy_ready", 32'(req_ready), 32'd0);
    reset = 1'b1;
    #1;
    $display("reset mid-rekey: rsp_valid=%0b locked=%0b", rsp_valid, locked);
    chk("mrst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("mrst_rsp_rdata", rsp_rdata, 32'd0);
    chk("mrst_locked", 32'(locked), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1 chk("mrst_ready", 32'(req_ready), 32'd1);
    txn(2'b00, 5'd31, 32'h0, RKEY, 0, lat, rd, er, fc, unst);
    chk("mrst_lat", lat, 2);
    chk("mrst_err", 32'(er), 32'd0);
    chk("mrst_rd31", rd, 32'hA88E_133D);
    txn(2'b00, 5'd0, 32'h0, RKEY, 0, lat, rd, er, fc, unst);
    chk("mrst_rd0", rd, 32'h6F5B_AA57);
    txn(2'b00, 5'd9, 32'h0, RKEY, 0, lat, rd, er, fc, unst);
    chk("mrst_rd9", rd, 32'h6652_A35E);
    txn(2'b00, 5'd10, 32'h0, RKEY, 0, lat, rd, er, fc, unst);
    chk("mrst_rd10", rd, 32'hBD9B_0628);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
